// File: rtl/wave_pkg.sv
// Shared constants and FSM state encoding for the square-wave meter.
//   SAMPLE_W : width of the ADC sample stream
//   CNT_W    : width of the period / high-time counters
//   state_t  : measurement FSM states
package wave_pkg;

  localparam int unsigned SAMPLE_W = 10;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/wave_hyst_slicer.sv
// Hysteresis slicer with registered edge detection.
//   DAC_clk : clock (rising edge)
//   rst_n   : asynchronous active-low reset
//   sample  : registered ADC sample
//   level   : sliced logic level (1 at/above HI_TH, 0 at/below LO_TH, else held)
//   rise    : one-cycle pulse, level went 0 -> 1
//   fall    : one-cycle pulse, level went 1 -> 0
module wave_hyst_slicer
  import wave_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] HI_TH = 10'd640,
  parameter logic [SAMPLE_W-1:0] LO_TH = 10'd384
) (
  input  logic                DAC_clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                level,
  output logic                rise,
  output logic                fall
);

  logic level_next;
  logic level_d;

  always_comb begin
    level_next = level;
    if (sample >= HI_TH) begin
      level_next = 1'b1;
    end else if (sample <= LO_TH) begin
      level_next = 1'b0;
    end
  end

  // Edges are taken from the registered level against its delayed copy,
  // giving the fixed three-edge input-to-measurement latency.
  always_ff @(posedge DAC_clk or negedge rst_n) begin
    if (!rst_n) begin
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      level   <= level_next;
      level_d <= level;
      rise    <= level & ~level_d;
      fall    <= ~level & level_d;
    end
  end

endmodule

// File: rtl/square_wave_meter.sv
// Square-wave period / high-time meter for a sampled ADC stream.
//   DAC_clk    : clock (rising edge)
//   rst_n      : asynchronous active-low reset
//   ADC_data   : unsigned sample, one per clock
//   period     : clocks between the last two rising edges
//   high_time  : clocks high within that period
//   meas_valid : one-cycle pulse when period/high_time update
//   no_signal  : set when the running counter saturates, cleared by a measurement
module square_wave_meter
  import wave_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] HI_TH = 10'd640,
  parameter logic [SAMPLE_W-1:0] LO_TH = 10'd384
) (
  input  logic                DAC_clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] ADC_data,
  output logic [CNT_W-1:0]    period,
  output logic [CNT_W-1:0]    high_time,
  output logic                meas_valid,
  output logic                no_signal
);

  logic [SAMPLE_W-1:0] sample_q;
  logic                level;
  logic                rise;
  logic                fall;
  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    high_cnt;

  always_ff @(posedge DAC_clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
    end else begin
      sample_q <= ADC_data;
    end
  end

  wave_hyst_slicer #(
    .HI_TH(HI_TH),
    .LO_TH(LO_TH)
  ) u_slicer (
    .DAC_clk(DAC_clk),
    .rst_n  (rst_n),
    .sample (sample_q),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  // The counter restarts at 1 on a rising edge so that its value on the
  // next edge equals the number of clocks elapsed since the previous one.
  // A saturated counter wins over a coincident edge.
  always_ff @(posedge DAC_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEEK;
      cnt        <= '0;
      high_cnt   <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        SEEK: begin
          if (rise) begin
            state <= HIGH;
            cnt   <= CNT_W'(1);
          end
        end
        HIGH: begin
          if (cnt == '1) begin
            state     <= SEEK;
            no_signal <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (fall) begin
              state    <= LOW;
              high_cnt <= cnt;
            end
          end
        end
        LOW: begin
          if (cnt == '1) begin
            state     <= SEEK;
            no_signal <= 1'b1;
            cnt       <= '0;
          end else if (rise) begin
            state      <= HIGH;
            period     <= cnt;
            high_time  <= high_cnt;
            meas_valid <= 1'b1;
            no_signal  <= 1'b0;
            cnt        <= CNT_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= SEEK;
          cnt   <= '0;
        end
      endcase
    end
  end

  logic unused_level;
  assign unused_level = level;

endmodule

// File: tb/tb_square_wave_meter.sv
// Self-checking bench for square_wave_meter: table-driven waveforms plus
// hand-written sequences for latency, band noise, timeout and mid-run reset.
module tb_square_wave_meter;

  logic        DAC_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [9:0]  ADC_data = '0;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        meas_valid;
  logic        no_signal;

  int tests = 0;
  int fails = 0;

  int mv_cnt = 0;
  int bad_cnt = 0;
  int stab_err = 0;
  int ns_hi = 0;
  int exp_p = 0;
  int exp_h = 0;
  logic [15:0] prev_p = '0;
  logic [15:0] prev_h = '0;
  logic        prev_rst = 1'b0;

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_p;
    int exp_h;
  } vec_t;

  vec_t vecs[5];

  square_wave_meter #(
    .HI_TH(10'd640),
    .LO_TH(10'd384)
  ) dut (
    .DAC_clk   (DAC_clk),
    .rst_n     (rst_n),
    .ADC_data  (ADC_data),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .no_signal (no_signal)
  );

  always #5 DAC_clk = ~DAC_clk;

  // Records every measurement pulse, flags values that differ from the
  // currently expected pair, and flags output changes without a pulse.
  always @(negedge DAC_clk) begin
    if (rst_n && meas_valid) begin
      mv_cnt++;
      if (period !== exp_p[15:0] || high_time !== exp_h[15:0]) bad_cnt++;
    end
    if (rst_n && no_signal) ns_hi++;
    if (rst_n && prev_rst && !meas_valid && (period !== prev_p || high_time !== prev_h))
      stab_err++;
    prev_p   = period;
    prev_h   = high_time;
    prev_rst = rst_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      ADC_data = v;
      @(posedge DAC_clk);
      #1;
    end
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      drive(10'h3FF, hi);
      drive(10'h000, lo);
    end
  endtask

  task automatic do_reset();
    ADC_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge DAC_clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int base_mv;
    int base_bad;
    int base_ns;
    int waited;

    vecs[0] = '{hi: 128, lo: 128, n: 4, exp_p: 256, exp_h: 128};
    vecs[1] = '{hi: 64,  lo: 192, n: 3, exp_p: 256, exp_h: 64};
    vecs[2] = '{hi: 1,   lo: 1,   n: 8, exp_p: 2,   exp_h: 1};
    vecs[3] = '{hi: 30,  lo: 70,  n: 3, exp_p: 100, exp_h: 30};
    vecs[4] = '{hi: 1,   lo: 3,   n: 4, exp_p: 4,   exp_h: 1};

    // Reset state
    repeat (2) @(posedge DAC_clk);
    #1;
    check("rst_period", period, 0);
    check("rst_high_time", high_time, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_no_signal", no_signal, 0);

    // Table-driven waveforms: n rising edges give n-1 measurements
    for (int v = 0; v < 5; v++) begin
      do_reset();
      exp_p = vecs[v].exp_p;
      exp_h = vecs[v].exp_h;
      base_mv  = mv_cnt;
      base_bad = bad_cnt;
      base_ns  = ns_hi;
      wave(vecs[v].hi, vecs[v].lo, vecs[v].n);
      drive(10'h000, 6);
      check($sformatf("vec%0d_meas_count", v), mv_cnt - base_mv, vecs[v].n - 1);
      check($sformatf("vec%0d_pulse_values", v), bad_cnt - base_bad, 0);
      check($sformatf("vec%0d_period", v), period, vecs[v].exp_p);
      check($sformatf("vec%0d_high_time", v), high_time, vecs[v].exp_h);
      check($sformatf("vec%0d_no_signal_cycles", v), ns_hi - base_ns, 0);
    end

    // Latency: completing rising sample captured at edge E0, pulse after E3
    do_reset();
    exp_p = 8;
    exp_h = 4;
    base_mv = mv_cnt;
    drive(10'h3FF, 4);
    drive(10'h000, 4);
    ADC_data = 10'h3FF;
    @(posedge DAC_clk);          // E0
    @(posedge DAC_clk);          // E1
    @(posedge DAC_clk);          // E2
    @(negedge DAC_clk);
    check("lat_e2_meas_valid", meas_valid, 0);
    @(posedge DAC_clk);          // E3
    @(negedge DAC_clk);
    check("lat_e3_meas_valid", meas_valid, 1);
    check("lat_period", period, 8);
    check("lat_high_time", high_time, 4);
    @(posedge DAC_clk);          // E4
    @(negedge DAC_clk);
    check("lat_e4_meas_valid", meas_valid, 0);
    @(posedge DAC_clk);
    #1;
    drive(10'h000, 6);
    check("lat_meas_count", mv_cnt - base_mv, 1);

    // Noise inside the hysteresis band on a 200-clock wave
    do_reset();
    exp_p = 200;
    exp_h = 100;
    base_mv  = mv_cnt;
    base_bad = bad_cnt;
    for (int k = 0; k < 3; k++) begin
      drive(10'h3FF, 10);
      for (int j = 0; j < 90; j++) drive((j % 2) ? 10'd520 : 10'd500, 1);
      drive(10'h000, 10);
      for (int j = 0; j < 90; j++) drive((j % 2) ? 10'd520 : 10'd500, 1);
    end
    drive(10'h000, 6);
    check("noise_meas_count", mv_cnt - base_mv, 2);
    check("noise_pulse_values", bad_cnt - base_bad, 0);
    check("noise_period", period, 200);
    check("noise_high_time", high_time, 100);

    // Timeout with input stuck high, then recovery
    do_reset();
    exp_p = 256;
    exp_h = 128;
    base_mv = mv_cnt;
    wave(128, 128, 2);
    ADC_data = 10'h3FF;
    waited = 0;
    while (!no_signal && waited < 70000) begin
      @(posedge DAC_clk);
      #1;
      waited++;
    end
    check("to_no_signal_set", no_signal, 1);
    check("to_meas_count", mv_cnt - base_mv, 2);
    check("to_period_kept", period, 256);
    check("to_high_time_kept", high_time, 128);
    base_mv = mv_cnt;
    drive(10'h3FF, 10);
    check("to_no_signal_held", no_signal, 1);
    exp_p = 100;
    exp_h = 50;
    drive(10'h000, 20);
    wave(50, 50, 1);
    check("to_first_edge_no_meas", mv_cnt - base_mv, 0);
    check("to_no_signal_after_1", no_signal, 1);
    wave(50, 50, 1);
    drive(10'h000, 6);
    check("to_recover_meas_count", mv_cnt - base_mv, 1);
    check("to_no_signal_cleared", no_signal, 0);
    check("to_recover_period", period, 100);
    check("to_recover_high_time", high_time, 50);

    // Reset pulsed while in LOW
    do_reset();
    exp_p = 256;
    exp_h = 128;
    base_mv = mv_cnt;
    wave(128, 128, 2);
    drive(10'h3FF, 128);
    drive(10'h000, 60);
    check("mid_pre_period", period, 256);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_period", period, 0);
    check("mid_rst_high_time", high_time, 0);
    check("mid_rst_meas_valid", meas_valid, 0);
    check("mid_rst_no_signal", no_signal, 0);
    @(negedge DAC_clk);
    @(posedge DAC_clk);
    #1;
    rst_n = 1'b1;
    base_mv = mv_cnt;
    drive(10'h000, 10);
    wave(128, 128, 1);
    check("mid_first_edge_no_meas", mv_cnt - base_mv, 0);
    check("mid_period_still_zero", period, 0);
    wave(128, 128, 1);
    drive(10'h000, 6);
    check("mid_meas_count", mv_cnt - base_mv, 1);
    check("mid_period", period, 256);
    check("mid_high_time", high_time, 128);

    check("outputs_stable_between_pulses", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
